// File: rtl/chacha_inv_qr_seq_if.sv
// chacha_inv_qr_seq_if
//   Handshake and data bundle for the sequential (inverse) ChaCha
//   quarterround engine.
//   Input side : in_valid / in_ready, encdec, a_in..d_in (a', b', c', d')
//   Output side: out_valid / out_ready, a_out..d_out (recovered a, b, c, d)
//   master : producer/consumer side (drives words in, accepts results)
//   slave  : the engine
interface chacha_inv_qr_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic        encdec;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] c_in;
    logic [31:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [31:0] c_out;
    logic [31:0] d_out;

    modport master (
        output in_valid, encdec, a_in, b_in, c_in, d_in, out_ready,
        input  in_ready, out_valid, a_out, b_out, c_out, d_out
    );

    modport slave (
        input  in_valid, encdec, a_in, b_in, c_in, d_in, out_ready,
        output in_ready, out_valid, a_out, b_out, c_out, d_out
    );
endinterface

// File: rtl/chacha_inv_qr_seq.sv
// chacha_inv_qr_seq
//   Sequential inverse ChaCha quarterround. Undoes one ARX line pair per
//   cycle (4 cycles per quarterround) and repeats NUM_ITER times on the
//   same four words before presenting the result.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-high
//     bus    - chacha_inv_qr_seq_if.slave (valid/ready in, valid/ready out)
//   Parameter:
//     NUM_ITER - back-to-back quarterrounds per transaction, 1..255
//   Optional build macro:
//     CHACHA_INV_QR_FWD_EN - when defined, encdec=1 at accept selects the
//     forward quarterround using the same states, counter and handshake.
module chacha_inv_qr_seq #(
    parameter int unsigned NUM_ITER = 1
) (
    input  logic              clk,
    input  logic              reset,
    chacha_inv_qr_seq_if.slave bus
);

    typedef enum logic [2:0] {IDLE, S3, S2, S1, S0, DONE} state_t;

    localparam logic [7:0] LAST_ITER = 8'(NUM_ITER - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] a_q, b_q, c_q, d_q;
    logic [31:0] a_d, b_d, c_d, d_d;
    logic        dir_fwd;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

`ifdef CHACHA_INV_QR_FWD_EN
    logic fwd_q;
    assign dir_fwd = fwd_q;
`else
    logic unused_encdec;
    assign unused_encdec = bus.encdec;
    assign dir_fwd       = 1'b0;
`endif

    // Word datapath. Inverse steps S2/S0 subtract the b register written in
    // the preceding S3/S1, which already holds the recovered b.
    // Forward mode reuses the same states as F0..F3 (S3=F0 ... S0=F3).
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d = bus.a_in;
                    b_d = bus.b_in;
                    c_d = bus.c_in;
                    d_d = bus.d_in;
                end
            end
            S3: begin
                if (dir_fwd) begin
                    a_d = a_q + b_q;
                    d_d = rotl32(d_q ^ (a_q + b_q), 16);
                end else begin
                    b_d = rotr32(b_q, 7) ^ c_q;
                    c_d = c_q - d_q;
                end
            end
            S2: begin
                if (dir_fwd) begin
                    c_d = c_q + d_q;
                    b_d = rotl32(b_q ^ (c_q + d_q), 12);
                end else begin
                    d_d = rotr32(d_q, 8) ^ a_q;
                    a_d = a_q - b_q;
                end
            end
            S1: begin
                if (dir_fwd) begin
                    a_d = a_q + b_q;
                    d_d = rotl32(d_q ^ (a_q + b_q), 8);
                end else begin
                    b_d = rotr32(b_q, 12) ^ c_q;
                    c_d = c_q - d_q;
                end
            end
            S0: begin
                if (dir_fwd) begin
                    c_d = c_q + d_q;
                    b_d = rotl32(b_q ^ (c_q + d_q), 7);
                end else begin
                    d_d = rotr32(d_q, 16) ^ a_q;
                    a_d = a_q - b_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
`ifdef CHACHA_INV_QR_FWD_EN
            fwd_q       <= 1'b0;
`endif
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            d_q <= d_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= S3;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
`ifdef CHACHA_INV_QR_FWD_EN
                        fwd_q      <= bus.encdec;
`endif
                    end
                end
                S3: state_q <= S2;
                S2: state_q <= S1;
                S1: state_q <= S0;
                S0: begin
                    if (cnt_q == LAST_ITER) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                        state_q <= S3;
                    end
                end
                DONE: begin
                    // Release goes straight to IDLE; no capture this cycle.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.c_out     = c_q;
    assign bus.d_out     = d_q;

endmodule

// File: tb/tb_chacha_inv_qr_seq.sv
// tb_chacha_inv_qr_seq
//   Two engines (NUM_ITER=1 and NUM_ITER=3) on a shared clock/reset.
//   Stimulus pushes expected results into per-engine queues; a monitor on
//   the falling edge compares whatever the engines present.
module tb_chacha_inv_qr_seq;

    localparam logic [127:0] QR_PLAIN = {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
    localparam logic [127:0] QR_MIXED = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
    localparam logic [127:0] WRAP_IN  = {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001};
    localparam logic [127:0] WRAP_OUT = {32'h00000001, 32'hffffffff, 32'hfeffffff, 32'h00000100};

    typedef struct {
        logic [127:0] exp;
        logic [127:0] src;
        bit           chk;
        int           due;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [1:0]   iv   = '0;
    logic [1:0]   enc  = '0;
    logic [1:0]   ordy = '1;
    logic [127:0] iw [2];
    logic [1:0]   ov;
    logic [1:0]   ird;
    logic [127:0] ow [2];
    logic [1:0]   ovp = '0;

    ent_t sbq [2][$];

    chacha_inv_qr_seq_if bus0 ();
    chacha_inv_qr_seq_if bus1 ();

    assign bus0.in_valid  = iv[0];
    assign bus0.encdec    = enc[0];
    assign bus0.out_ready = ordy[0];
    assign {bus0.a_in, bus0.b_in, bus0.c_in, bus0.d_in} = iw[0];
    assign bus1.in_valid  = iv[1];
    assign bus1.encdec    = enc[1];
    assign bus1.out_ready = ordy[1];
    assign {bus1.a_in, bus1.b_in, bus1.c_in, bus1.d_in} = iw[1];

    assign ov    = {bus1.out_valid, bus0.out_valid};
    assign ird   = {bus1.in_ready, bus0.in_ready};
    assign ow[0] = {bus0.a_out, bus0.b_out, bus0.c_out, bus0.d_out};
    assign ow[1] = {bus1.a_out, bus1.b_out, bus1.c_out, bus1.d_out};

    chacha_inv_qr_seq #(.NUM_ITER(1)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    chacha_inv_qr_seq #(.NUM_ITER(3)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int niter(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr_fwd(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = x;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    task automatic send(input int k, input logic [127:0] w, input logic e,
                        input logic [127:0] exp, input bit fchk);
        ent_t en;
        int   g;
        g = 0;
        @(negedge clk);
        while (!ird[k] && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("in_ready_timeout", k, 128'(ird[k]), 128'd1);
        iv[k]  = 1'b1;
        iw[k]  = w;
        enc[k] = e;
        @(posedge clk);
        #1;
        iv[k]  = 1'b0;
        en.exp = exp;
        en.src = w;
        en.chk = fchk;
        en.due = cyc + 4 * niter(k);
        sbq[k].push_back(en);
        @(negedge clk);
        chk("in_ready_after_accept", k, 128'(ird[k]), 128'd0);
    endtask

    task automatic wait_done(input int k);
        int g;
        g = 0;
        while (sbq[k].size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) chk("result_timeout", k, 128'(sbq[k].size()), 128'd0);
        @(negedge clk);
        chk("in_ready_idle", k, 128'(ird[k]), 128'd1);
        chk("out_valid_dropped", k, 128'(ov[k]), 128'd0);
    endtask

    // Monitor: latency on the rising out_valid, data every valid cycle
    // (covers stability under backpressure), round trip on handshake.
    always @(negedge clk) begin : monitor
        ent_t         e;
        logic [127:0] r;
        if (reset) begin
            ovp = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ov[k]) begin
                    if (sbq[k].size() == 0) begin
                        chk("unexpected_output", k, ow[k], 128'd0);
                        if (ow[k] == 128'd0) begin
                            fails++;
                            $display("FAIL unexpected_output dut%0d: got out_valid=1 expected 0", k);
                        end
                    end else begin
                        e = sbq[k][0];
                        if (!ovp[k]) chk("latency", k, 128'(cyc), 128'(e.due));
                        chk("in_ready_in_done", k, 128'(ird[k]), 128'd0);
                        chk("data", k, ow[k], e.exp);
                        if (ordy[k]) begin
                            void'(sbq[k].pop_front());
                            if (e.chk) begin
                                r = ow[k];
                                for (int i = 0; i < niter(k); i++) r = qr_fwd(r);
                                chk("fwd_roundtrip", k, r, e.src);
                            end
                        end
                    end
                end
                ovp[k] = ov[k];
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] x3;
        iw[0] = '0;
        iw[1] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_in_ready", k, 128'(ird[k]), 128'd1);
            chk("reset_out_valid", k, 128'(ov[k]), 128'd0);
            chk("reset_words", k, ow[k], 128'd0);
        end
        reset = 1'b0;

        // Single inverse quarterround, RFC 7539 2.1.1
        send(0, QR_MIXED, 1'b0, QR_PLAIN, 1'b1);
        wait_done(0);

        // out_ready pulsed while idle has no visible effect
        @(negedge clk);
        chk("idle_out_valid", 0, 128'(ov[0]), 128'd0);

        // Backpressure with a stray in_valid while busy
        ordy[0] = 1'b0;
        send(0, QR_MIXED, 1'b0, QR_PLAIN, 1'b1);
        @(negedge clk);
        iv[0] = 1'b1;
        iw[0] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        @(negedge clk);
        iv[0] = 1'b0;
        begin
            int g;
            g = 0;
            while (!ov[0] && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) chk("bp_valid_timeout", 0, 128'(ov[0]), 128'd1);
        end
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        wait_done(0);

        // Three iterations
        x3 = qr_fwd(qr_fwd(qr_fwd(QR_PLAIN)));
        send(1, x3, 1'b0, QR_PLAIN, 1'b1);
        wait_done(1);

        // Reset during S2
        @(negedge clk);
        iv[0]  = 1'b1;
        iw[0]  = QR_MIXED;
        enc[0] = 1'b0;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 0, 128'(ov[0]), 128'd0);
        chk("abort_in_ready", 0, 128'(ird[0]), 128'd1);
        chk("abort_words", 0, ow[0], 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send(0, QR_MIXED, 1'b0, QR_PLAIN, 1'b1);
        wait_done(0);

        // Wrap-around of c-d and a-b
        send(0, WRAP_IN, 1'b0, WRAP_OUT, 1'b1);
        wait_done(0);

`ifdef CHACHA_INV_QR_FWD_EN
        send(0, QR_PLAIN, 1'b1, QR_MIXED, 1'b0);
        wait_done(0);
        send(0, QR_MIXED, 1'b0, QR_PLAIN, 1'b1);
        wait_done(0);
`endif

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) chk("scoreboard_empty", k, 128'(sbq[k].size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
